uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one `uart_transimitter` instance between up to `NUM_REQ` requesters, each delivering 16-bit words. Each word is sent as two UART frames, MSB byte first. The block sits between the requesting logic and the transmitter. It owns the transmitter's `Tx_Data`, `Tx_WR`, `Tx_EN` and `baud_select` inputs, and it sequences the `Tx_WR` pulse and `Tx_BUSY` handshake per byte. A receiver on the far end therefore sees back-to-back byte pairs separated by a guaranteed idle gap.

---
 rtl/uart_ctrl_pkg.sv | 30 +++
 rtl/uart_rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler and its arbiter.
// Baud codes match the encoding used by the transmitter and receiver.
package uart_ctrl_pkg;

   localparam int UART_WORD_W = 16;
   localparam int UART_BYTE_W = 8;

   localparam logic [2:0] BAUD_300    = 3'b000;
   localparam logic [2:0] BAUD_1200   = 3'b001;
   localparam logic [2:0] BAUD_4800   = 3'b010;
   localparam logic [2:0] BAUD_9600   = 3'b011;
   localparam logic [2:0] BAUD_19200  = 3'b100;
   localparam logic [2:0] BAUD_38400  = 3'b101;
   localparam logic [2:0] BAUD_57600  = 3'b110;
   localparam logic [2:0] BAUD_115200 = 3'b111;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      GAP     = 3'd4
   } sched_state_t;

   function automatic logic [UART_BYTE_W-1:0] word_byte(input logic [UART_WORD_W-1:0] w,
                                                         input logic lo_sel);
      return lo_sel ? w[UART_BYTE_W-1:0] : w[UART_WORD_W-1:UART_BYTE_W];
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
// The pointer itself is owned by the scheduler.
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [PTR_W-1:0]   pick_idx
);

   // scan from the pointer, wrapping, and keep the first hit
   always_comb begin
      int               sum;
      logic [PTR_W-1:0] idx;
      logic             found;
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      sum      = 0;
      idx      = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = int'(ptr) + off;
         idx = (sum >= NUM_REQ) ? PTR_W'(sum - NUM_REQ) : PTR_W'(sum);
         if (!found && req[idx]) begin
            found     = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = idx;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ word sources.
// Each 16-bit word goes out as two frames, MSB byte first, followed by an idle gap.
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [UART_WORD_W*NUM_REQ-1:0] word_data,
   input  logic [2:0]                     cfg_baud_select,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           done,
   output logic                           word_err,
   output logic [UART_BYTE_W-1:0]         Tx_Data,
   output logic                           Tx_WR,
   output logic                           Tx_EN,
   output logic [2:0]                     baud_select,
   input  logic                           Tx_BUSY
);

   localparam int               PTR_W    = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
   localparam logic [7:0]       TO_LIMIT = 8'(BUSY_TIMEOUT);
   localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);

   sched_state_t             state_r, state_s;
   logic [UART_WORD_W-1:0]   words_s [NUM_REQ];
   logic [UART_WORD_W-1:0]   word_q_r, word_q_s;
   logic [NUM_REQ-1:0]       grant_r, grant_s, pick_s;
   logic [PTR_W-1:0]         ptr_r, ptr_s, idx_r, idx_s, pick_idx_s;
   logic                     byte_idx_r, byte_idx_s;
   logic [7:0]               to_cnt_r, to_cnt_s, gap_cnt_r, gap_cnt_s;
   logic [UART_BYTE_W-1:0]   tx_data_r, tx_data_s;
   logic                     tx_wr_r, tx_wr_s, tx_en_r, tx_en_s;
   logic [2:0]               baud_r, baud_s;
   logic                     done_r, done_s, err_r, err_s;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
      assign words_s[g] = word_data[UART_WORD_W*g +: UART_WORD_W];
   end

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req      (req),
      .ptr      (ptr_r),
      .pick     (pick_s),
      .pick_idx (pick_idx_s)
   );

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         word_q_r   <= '0;
         grant_r    <= '0;
         ptr_r      <= '0;
         idx_r      <= '0;
         byte_idx_r <= 1'b0;
         to_cnt_r   <= 8'd0;
         gap_cnt_r  <= 8'd0;
         tx_data_r  <= '0;
         tx_wr_r    <= 1'b0;
         tx_en_r    <= 1'b0;
         baud_r     <= 3'b000;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         word_q_r   <= word_q_s;
         grant_r    <= grant_s;
         ptr_r      <= ptr_s;
         idx_r      <= idx_s;
         byte_idx_r <= byte_idx_s;
         to_cnt_r   <= to_cnt_s;
         gap_cnt_r  <= gap_cnt_s;
         tx_data_r  <= tx_data_s;
         tx_wr_r    <= tx_wr_s;
         tx_en_r    <= tx_en_s;
         baud_r     <= baud_s;
         done_r     <= done_s;
         err_r      <= err_s;
      end
   end

   // next-state and next-output logic; pulses default low, everything else holds
   always_comb begin
      state_s    = state_r;
      word_q_s   = word_q_r;
      grant_s    = grant_r;
      ptr_s      = ptr_r;
      idx_s      = idx_r;
      byte_idx_s = byte_idx_r;
      to_cnt_s   = to_cnt_r;
      gap_cnt_s  = gap_cnt_r;
      tx_data_s  = tx_data_r;
      tx_wr_s    = 1'b0;
      tx_en_s    = tx_en_r;
      baud_s     = baud_r;
      done_s     = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (|req) begin
               word_q_s   = words_s[pick_idx_s];
               baud_s     = cfg_baud_select;
               grant_s    = pick_s;
               idx_s      = pick_idx_s;
               tx_en_s    = 1'b1;
               tx_data_s  = word_byte(words_s[pick_idx_s], 1'b0);
               byte_idx_s = 1'b0;
               tx_wr_s    = 1'b1;
               state_s    = WR;
            end else begin
               state_s = IDLE;
            end
         end
         WR: begin
            to_cnt_s = 8'd0;
            state_s  = WAIT_HI;
         end
         WAIT_HI: begin
            if (Tx_BUSY) begin
               state_s = WAIT_LO;
            end else if (to_cnt_r == TO_LIMIT) begin
               done_s    = 1'b1;
               err_s     = 1'b1;
               gap_cnt_s = 8'd0;
               state_s   = GAP;
            end else begin
               to_cnt_s = (to_cnt_r == 8'hFF) ? to_cnt_r : to_cnt_r + 8'd1;
            end
         end
         WAIT_LO: begin
            if (Tx_BUSY) begin
               state_s = WAIT_LO;
            end else if (!byte_idx_r) begin
               tx_data_s  = word_byte(word_q_r, 1'b1);
               byte_idx_s = 1'b1;
               tx_wr_s    = 1'b1;
               state_s    = WR;
            end else begin
               done_s    = 1'b1;
               gap_cnt_s = 8'd0;
               state_s   = GAP;
            end
         end
         GAP: begin
            // grant stays visible during the done cycle, then drops with Tx_EN
            if (done_r) begin
               grant_s = '0;
               tx_en_s = 1'b0;
               ptr_s   = (idx_r == LAST_IDX) ? '0 : idx_r + 1'b1;
            end else begin
               grant_s = grant_r;
            end
            if (gap_cnt_r == GAP_LAST) begin
               state_s = IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + 8'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign grant       = grant_r;
   assign done        = done_r;
   assign word_err    = err_r;
   assign Tx_Data     = tx_data_r;
   assign Tx_WR       = tx_wr_r;
   assign Tx_EN       = tx_en_r;
   assign baud_select = baud_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural transmitter stub
// that captures each written byte and answers with a Tx_BUSY pulse.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] word_data;
   logic [2:0]  cfg_baud_select;
   logic [3:0]  grant;
   logic        done, word_err;
   logic [7:0]  Tx_Data;
   logic        Tx_WR, Tx_EN;
   logic [2:0]  baud_select;
   logic        Tx_BUSY = 1'b0;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  bytes_q[$];
   int          wr_seen = 0;
   int          bsy_t = 0;
   logic        stub_dead = 1'b0;

   uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(16), .BUSY_TIMEOUT(64)) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .word_data       (word_data),
      .cfg_baud_select (cfg_baud_select),
      .grant           (grant),
      .done            (done),
      .word_err        (word_err),
      .Tx_Data         (Tx_Data),
      .Tx_WR           (Tx_WR),
      .Tx_EN           (Tx_EN),
      .baud_select     (baud_select),
      .Tx_BUSY         (Tx_BUSY)
   );

   always #5 clk = ~clk;

   // transmitter stub: busy from 2 to 9 cycles after a write, unless tied low
   always @(negedge clk) begin
      if (Tx_WR) begin
         bytes_q.push_back(Tx_Data);
         wr_seen = wr_seen + 1;
         bsy_t = 1;
      end else if (bsy_t != 0) begin
         bsy_t = bsy_t + 1;
      end
      if (bsy_t >= 11) bsy_t = 0;
      Tx_BUSY = !stub_dead && (bsy_t >= 3);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req = 4'b0000;
      stub_dead = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bytes_q.delete();
      wr_seen = 0;
   endtask

   task automatic wait_done(input string tag, output logic [3:0] g, output logic e);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 400);
      if (!done) check({tag, "_done_timeout"}, {31'd0, done}, 32'd1);
      g = grant;
      e = word_err;
   endtask

   initial begin
      logic [3:0] g;
      logic       e;
      int         k;

      word_data = 64'd0;
      cfg_baud_select = 3'b000;
      reset = 1'b0;
      req = 4'b0000;
      #2;
      check("rst_outputs", {16'd0, grant, done, word_err, Tx_Data, Tx_WR, Tx_EN}, 32'd0);
      check("rst_baud", {29'd0, baud_select}, 32'd0);

      // single requester, gap, and baud latched only at grant
      do_reset();
      word_data = {48'd0, 16'hA55A};
      cfg_baud_select = 3'b111;
      req = 4'b0001;
      @(negedge clk);
      check("t1_grant", {28'd0, grant}, 32'h1);
      check("t1_en", {31'd0, Tx_EN}, 32'd1);
      check("t1_wr", {31'd0, Tx_WR}, 32'd1);
      check("t1_data", {24'd0, Tx_Data}, 32'hA5);
      check("t1_baud", {29'd0, baud_select}, 32'h7);
      cfg_baud_select = 3'b100;
      wait_done("t1", g, e);
      check("t1_done_grant", {28'd0, g}, 32'h1);
      check("t1_err", {31'd0, e}, 32'd0);
      check("t1_baud_hold", {29'd0, baud_select}, 32'h7);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!Tx_EN && k < 40);
      check("t1_gap_len", k, 32'd17);
      check("t1_regrant", {28'd0, grant}, 32'h1);
      check("t1_baud_new", {29'd0, baud_select}, 32'h4);
      req = 4'b0000;
      wait_done("t1b", g, e);
      check("t1_nbytes", bytes_q.size(), 32'd4);
      check("t1_b0", {24'd0, bytes_q[0]}, 32'hA5);
      check("t1_b1", {24'd0, bytes_q[1]}, 32'h5A);

      // all four requesting: round-robin order and byte stream
      do_reset();
      word_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_done("t2", g, e);
         check("t2_grant", {28'd0, g}, 32'd1 << (i % 4));
      end
      req = 4'b0000;
      check("t2_nbytes", bytes_q.size(), 32'd10);
      for (int j = 0; j < 8; j++) begin
         check("t2_byte", {24'd0, bytes_q[j]}, (j / 2 + 1) * 32'h11);
      end

      // transmitter never goes busy: timeout abort
      do_reset();
      stub_dead = 1'b1;
      word_data = {48'd0, 16'hC3C3};
      req = 4'b0001;
      k = 0;
      while (!Tx_WR && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("t3_first_wr", {31'd0, Tx_WR}, 32'd1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 200);
      check("t3_latency", k, 32'd66);
      check("t3_err", {31'd0, word_err}, 32'd1);
      check("t3_grant_at_done", {28'd0, grant}, 32'h1);
      req = 4'b0000;
      @(negedge clk);
      check("t3_grant_clear", {28'd0, grant}, 32'h0);
      repeat (30) @(negedge clk);
      check("t3_wr_count", wr_seen, 32'd1);

      // req drop and data change after grant are ignored
      do_reset();
      word_data = {32'd0, 16'hBEEF, 16'd0};
      req = 4'b0010;
      k = 0;
      while (!Tx_WR && k < 10) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      req = 4'b0000;
      word_data = {32'd0, 16'hFFFF, 16'd0};
      wait_done("t4", g, e);
      check("t4_grant", {28'd0, g}, 32'h2);
      check("t4_err", {31'd0, e}, 32'd0);
      check("t4_nbytes", bytes_q.size(), 32'd2);
      check("t4_b0", {24'd0, bytes_q[0]}, 32'hBE);
      check("t4_b1", {24'd0, bytes_q[1]}, 32'hEF);
      repeat (30) @(negedge clk);
      check("t4_idle", {28'd0, grant}, 32'h0);

      // reset during the second byte, then a fresh grant from pointer 0
      do_reset();
      word_data = {48'd0, 16'h1234};
      req = 4'b0001;
      k = 0;
      while (wr_seen < 2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      check("t5_pre_en", {31'd0, Tx_EN}, 32'd1);
      check("t5_pre_data", {24'd0, Tx_Data}, 32'h34);
      reset = 1'b0;
      #1;
      check("t5_async_clear", {16'd0, grant, done, word_err, Tx_Data, Tx_WR, Tx_EN}, 32'd0);
      check("t5_async_baud", {29'd0, baud_select}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      req = 4'b0100;
      word_data = {16'd0, 16'h5678, 32'd0};
      @(negedge clk);
      check("t5_grant2", {28'd0, grant}, 32'h4);
      wait_done("t5", g, e);
      check("t5_done_grant", {28'd0, g}, 32'h4);
      req = 4'b0000;
      check("t5_nbytes", bytes_q.size(), 32'd4);
      check("t5_b2", {24'd0, bytes_q[2]}, 32'h56);
      check("t5_b3", {24'd0, bytes_q[3]}, 32'h78);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
